// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall requests, sequences jump flushes, defers them behind data waits.
// Optional perf counters are built when PIPE_STALL_CTRL_PERF_EN is defined.
module pipe_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_stall_req,
    input  logic        alu_stall_req,
    input  logic        biu_if_wait,
    input  logic        biu_data_wait,
    input  logic        jump_flag,
    input  logic [31:0] jump_addr,
    output logic [5:0]  stall,
    output logic        pc_load,
    output logic [31:0] pc_load_addr,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI    = (FLUSH_CYCLES > 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pend_q, pend_d;
    logic        flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        flush        = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = 32'd0;
        case (state_q)
            IDLE: begin
                if (jump_flag) begin
                    if (biu_data_wait) begin
                        pend_d  = jump_addr;
                        state_d = PEND;
                    end else begin
                        flush        = 1'b1;
                        pc_load      = 1'b1;
                        pc_load_addr = jump_addr;
                        if (MULTI) begin
                            state_d = FLUSH;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            PEND: begin
                // New jumps are ignored here; the captured target wins.
                if (!biu_data_wait) begin
                    flush        = 1'b1;
                    pc_load      = 1'b1;
                    pc_load_addr = pend_q;
                    if (MULTI) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (!biu_data_wait) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            flush        = 1'b0;
            pc_load      = 1'b0;
            pc_load_addr = 32'd0;
        end
    end

    always_comb begin
        stall = 6'b000000;
        if (!rst_n)             stall = 6'b000000;
        else if (biu_data_wait) stall = 6'b011111;
        else if (flush)         stall = 6'b111111;
        else if (alu_stall_req) stall = 6'b001111;
        else if (de_stall_req)  stall = 6'b000111;
        else if (biu_if_wait)   stall = 6'b000011;
    end

`ifdef PIPE_STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (stall != 6'b000000 && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (pc_load && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'h0;
    assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; u3 uses FLUSH_CYCLES=3, u2 uses FLUSH_CYCLES=2 on shared inputs.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de_stall_req, alu_stall_req, biu_if_wait, biu_data_wait, jump_flag;
    logic [31:0] jump_addr;
    logic [5:0]  stall3, stall2;
    logic        pc_load3, pc_load2;
    logic [31:0] pc_addr3, pc_addr2, sc3, sc2, fc3, fc2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.FLUSH_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .de_stall_req(de_stall_req), .alu_stall_req(alu_stall_req),
        .biu_if_wait(biu_if_wait), .biu_data_wait(biu_data_wait), .jump_flag(jump_flag),
        .jump_addr(jump_addr), .stall(stall3), .pc_load(pc_load3), .pc_load_addr(pc_addr3),
        .stall_cycles(sc3), .flush_count(fc3)
    );

    pipe_stall_ctrl #(.FLUSH_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .de_stall_req(de_stall_req), .alu_stall_req(alu_stall_req),
        .biu_if_wait(biu_if_wait), .biu_data_wait(biu_data_wait), .jump_flag(jump_flag),
        .jump_addr(jump_addr), .stall(stall2), .pc_load(pc_load2), .pc_load_addr(pc_addr2),
        .stall_cycles(sc2), .flush_count(fc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        de_stall_req = 0; alu_stall_req = 0; biu_if_wait = 0;
        biu_data_wait = 0; jump_flag = 0; jump_addr = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle_in();
        tick();
        rst_n = 1;
    endtask

    initial begin
        // Reset with every request asserted
        rst_n = 0;
        de_stall_req = 1; alu_stall_req = 1; biu_if_wait = 1;
        biu_data_wait = 1; jump_flag = 1; jump_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_stall", {26'd0, stall3}, 32'h00);
            chk("rst_pcload", {31'd0, pc_load3}, 32'h0);
            chk("rst_addr", pc_addr3, 32'h0);
            tick();
        end
        rst_n = 1; idle_in();
        @(negedge clk);
        chk("post_rst_stall", {26'd0, stall3}, 32'h00);
        chk("post_rst_sc", sc3, 32'h0);
        chk("post_rst_fc", fc3, 32'h0);
        tick();

        // Priority
        de_stall_req = 1; alu_stall_req = 1;
        @(negedge clk); chk("prio_alu", {26'd0, stall3}, 32'h0F); tick();
        biu_data_wait = 1;
        @(negedge clk); chk("prio_data", {26'd0, stall3}, 32'h1F); tick();
        idle_in(); biu_if_wait = 1;
        @(negedge clk); chk("prio_if", {26'd0, stall3}, 32'h03); tick();
        idle_in(); de_stall_req = 1;
        @(negedge clk); chk("prio_de", {26'd0, stall3}, 32'h07); tick();

        // Jump with FLUSH_CYCLES=3; simultaneous alu request is dropped by the flush
        idle_in(); jump_flag = 1; jump_addr = 32'h0000_0100; alu_stall_req = 1;
        @(negedge clk);
        chk("jmp_pcload", {31'd0, pc_load3}, 32'h1);
        chk("jmp_addr", pc_addr3, 32'h100);
        chk("jmp_stall0", {26'd0, stall3}, 32'h3F);
        tick();
        idle_in();
        @(negedge clk);
        chk("jmp_stall1", {26'd0, stall3}, 32'h3F);
        chk("jmp_pcload1", {31'd0, pc_load3}, 32'h0);
        chk("jmp_addr1", pc_addr3, 32'h0);
        tick();
        jump_flag = 1; jump_addr = 32'h0000_0999;  // ignored while flushing
        @(negedge clk);
        chk("jmp_stall2", {26'd0, stall3}, 32'h3F);
        chk("jmp_ignored", {31'd0, pc_load3}, 32'h0);
        tick();
        idle_in();
        @(negedge clk); chk("jmp_done", {26'd0, stall3}, 32'h00); tick();

        // Deferred jump behind a data wait
        biu_data_wait = 1; jump_flag = 1; jump_addr = 32'h200;
        @(negedge clk);
        chk("def_c1_stall", {26'd0, stall3}, 32'h1F);
        chk("def_c1_pcload", {31'd0, pc_load3}, 32'h0);
        tick();
        jump_addr = 32'h300;
        @(negedge clk);
        chk("def_c2_stall", {26'd0, stall3}, 32'h1F);
        chk("def_c2_pcload", {31'd0, pc_load3}, 32'h0);
        tick();
        jump_flag = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("def_c34_stall", {26'd0, stall3}, 32'h1F);
            chk("def_c34_pcload", {31'd0, pc_load3}, 32'h0);
            tick();
        end
        idle_in();
        @(negedge clk);
        chk("def_c5_pcload", {31'd0, pc_load3}, 32'h1);
        chk("def_c5_addr", pc_addr3, 32'h200);
        chk("def_c5_stall", {26'd0, stall3}, 32'h3F);
        tick();
        @(negedge clk); chk("def_c6_stall", {26'd0, stall3}, 32'h3F); tick();
        @(negedge clk); chk("def_c7_stall", {26'd0, stall3}, 32'h3F); tick();
        @(negedge clk); chk("def_done", {26'd0, stall3}, 32'h00); tick();

        // Data wait during FLUSH, FLUSH_CYCLES=2
        do_reset();
        jump_flag = 1; jump_addr = 32'h0000_0440;
        @(negedge clk);
        chk("fw_pcload", {31'd0, pc_load2}, 32'h1);
        chk("fw_addr", pc_addr2, 32'h440);
        chk("fw_stall0", {26'd0, stall2}, 32'h3F);
        tick();
        idle_in(); biu_data_wait = 1;
        @(negedge clk); chk("fw_frz1", {26'd0, stall2}, 32'h1F); tick();
        @(negedge clk); chk("fw_frz2", {26'd0, stall2}, 32'h1F); tick();
        biu_data_wait = 0;
        @(negedge clk);
        chk("fw_last", {26'd0, stall2}, 32'h3F);
        chk("fw_last_pcload", {31'd0, pc_load2}, 32'h0);
        tick();
        @(negedge clk); chk("fw_idle", {26'd0, stall2}, 32'h00); tick();

        // Reset while in PEND drops the jump
        biu_data_wait = 1; jump_flag = 1; jump_addr = 32'h400;
        tick();
        jump_flag = 0;
        tick();
        rst_n = 0; biu_data_wait = 0;
        @(negedge clk); chk("rp_rst_pcload", {31'd0, pc_load3}, 32'h0); tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rp_no_pcload", {31'd0, pc_load3}, 32'h0);
            chk("rp_stall", {26'd0, stall3}, 32'h00);
            tick();
        end

        // Perf counters: 5 stall cycles plus one jump
        do_reset();
        de_stall_req = 1;
        repeat (5) tick();
        idle_in(); jump_flag = 1; jump_addr = 32'h500;
        tick();
        idle_in();
        tick(); tick();
        @(negedge clk);
        chk("perf_idle", {26'd0, stall3}, 32'h00);
`ifdef PIPE_STALL_CTRL_PERF_EN
        chk("perf_sc3", sc3, 32'd8);
        chk("perf_fc3", fc3, 32'd1);
        chk("perf_sc2", sc2, 32'd7);
        chk("perf_fc2", fc2, 32'd1);
`else
        chk("perf_sc3_off", sc3, 32'd0);
        chk("perf_fc3_off", fc3, 32'd0);
        chk("perf_sc2_off", sc2, 32'd0);
        chk("perf_fc2_off", fc2, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central pipeline hazard controller that drives the 6-bit `stall` vector consumed by every inter-stage register, plus the PC redirect on taken jumps. It merges stall requests from decode (load-use), the ALU (multi-cycle ops) and the BIU (fetch/data wait). It sequences jump flushes and defers them while a data access is pending. It sits beside the pipeline and is the producing end of the stall interface that the stage registers obey.

## Interface
Parameters:
- FLUSH_CYCLES, 1: cycles `stall` is held at 6'b111111 per jump; legal range 1..7.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- de_stall_req  in  1  load-use hazard from decode
- alu_stall_req  in  1  multi-cycle ALU op (div) not finished
- biu_if_wait  in  1  instruction fetch not yet returned
- biu_data_wait  in  1  load/store in MEM stage not yet acknowledged
- jump_flag  in  1  taken branch/jump resolved in ALU stage
- jump_addr  in  32  jump target
- stall  out  6  bit0 PC, bit1 IF/DE, bit2 DE/ALU, bit3 ALU/MEM, bit4 MEM/WB, bit5 WB; all-ones = flush
- pc_load  out  1  one-cycle PC redirect strobe
- pc_load_addr  out  32  redirect target, valid with pc_load
- stall_cycles  out  32  perf counter (see Configuration)
- flush_count  out  32  perf counter (see Configuration)

## Operation
- Stage rule (consumer contract): stage register n holds when stall[n]=1 and stall[n+1]=1; inserts bubble when stall[n]=1 and stall[n+1]=0; loads when stall[n]=0; clears on all-ones.
- FSM states: IDLE, PEND (jump captured, waiting for data access), FLUSH (extra flush cycles).
- `stall` is combinational from inputs and FSM state. Priority, highest first:
  - biu_data_wait=1 -> 6'b011111.
  - Flush active (see below) -> 6'b111111.
  - alu_stall_req=1 -> 6'b001111.
  - de_stall_req=1 -> 6'b000111.
  - biu_if_wait=1 -> 6'b000011.
  - Otherwise 6'b000000.
- Jump in IDLE with biu_data_wait=0:
  - Flush active this cycle; pc_load=1; pc_load_addr=jump_addr.
  - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
- Jump in IDLE with biu_data_wait=1:
  - Latch jump_addr into pend_addr; go to PEND; no pc_load.
- PEND:
  - Hold while biu_data_wait=1. jump_flag/jump_addr are ignored in this state; the captured target is kept.
  - On the first cycle biu_data_wait=0: flush active, pc_load=1, pc_load_addr=pend_addr. Then go to FLUSH or IDLE, as above.
- FLUSH:
  - Flush active each cycle; counter decrements; return to IDLE when counter reaches 0.
  - jump_flag is ignored; the pipeline is being cleared.
  - biu_data_wait=1 overrides `stall` to 6'b011111 and freezes the counter.
- pc_load_addr is 0 whenever pc_load=0.

## Timing
- Reset (rst_n low at a clk edge): FSM->IDLE, counter=0, pend_addr=0, perf counters=0. While rst_n=0, `stall`=6'b000000, pc_load=0, pc_load_addr=0.
- Reset mid-PEND or mid-FLUSH drops the pending jump; no pc_load is issued afterwards.
- Zero-latency request->stall (same cycle). pc_load is asserted in the same cycle as the first flush cycle.
- Total flush duration is exactly FLUSH_CYCLES cycles with stall=111111, excluding cycles frozen by biu_data_wait.
- Simultaneous jump_flag and alu_stall_req/de_stall_req: flush wins; requests are dropped with the flushed instructions.

## Configuration
- PIPE_STALL_CTRL_PERF_EN defined: the following 32-bit saturating counters are built; both saturate at 32'hFFFF_FFFF.
  - stall_cycles increments every cycle where stall≠0.
  - flush_count increments on every pc_load.
- Not defined: stall_cycles and flush_count are tied to 32'h0 and no counter flops exist.

## Test plan
- Reset: hold rst_n=0 with all requests=1 for 3 cycles -> stall=000000, pc_load=0. Release with no requests -> stall=000000.
- Priority: de_stall_req=1, alu_stall_req=1 -> 001111. Add biu_data_wait=1 -> 011111. Drop all but biu_if_wait -> 000011.
- Jump, FLUSH_CYCLES=3: jump_flag=1, jump_addr=32'h0000_0100 for 1 cycle -> pc_load=1 with addr 32'h100 in that cycle. stall=111111 for exactly 3 cycles, then 000000.
- Deferred jump: biu_data_wait=1 for 4 cycles; jump_flag=1, addr 32'h200 in cycle 1, changed to 32'h300 in cycle 2.
  - Cycles 1-4: stall=011111, pc_load=0.
  - Cycle 5: pc_load=1 with addr 32'h200, stall=111111.
- Data wait during FLUSH, FLUSH_CYCLES=2: biu_data_wait=1 for 2 cycles, starting in the second flush cycle -> stall=011111 for those 2 cycles, then 1 more cycle of 111111, then IDLE.
- Reset in PEND, plus perf counters (macro on):
  - Assert rst_n=0 in PEND; release -> no pc_load ever fires.
  - With PIPE_STALL_CTRL_PERF_EN: 5 stall cycles + 1 jump -> stall_cycles=5+FLUSH_CYCLES, flush_count=1.
